// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundle of the two requester ports and the DataMemory-side port.
// Requester 0 = core LSU, requester 1 = loader/debug.
// slave  : the arbiter's view
// master : the requesters' and DataMemory's view
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Requester 0
  logic              REQ_0;
  logic              WE_0;
  logic [2:0]        FUNC3_0;
  logic [ADDR_W-1:0] ADDR_0;
  logic [DATA_W-1:0] WDATA_0;
  logic              GNT_0;
  logic              RVALID_0;
  logic [DATA_W-1:0] RDATA_0;
  // Requester 1
  logic              REQ_1;
  logic              WE_1;
  logic [2:0]        FUNC3_1;
  logic [ADDR_W-1:0] ADDR_1;
  logic [DATA_W-1:0] WDATA_1;
  logic              GNT_1;
  logic              RVALID_1;
  logic [DATA_W-1:0] RDATA_1;
  // DataMemory side
  logic              MRd;
  logic              MWrt;
  logic [2:0]        FUNC3;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] W_DATA;
  logic [DATA_W-1:0] R_DATA;

  modport slave (
    input  REQ_0, WE_0, FUNC3_0, ADDR_0, WDATA_0,
    output GNT_0, RVALID_0, RDATA_0,
    input  REQ_1, WE_1, FUNC3_1, ADDR_1, WDATA_1,
    output GNT_1, RVALID_1, RDATA_1,
    output MRd, MWrt, FUNC3, ADDR, W_DATA,
    input  R_DATA
  );

  modport master (
    output REQ_0, WE_0, FUNC3_0, ADDR_0, WDATA_0,
    input  GNT_0, RVALID_0, RDATA_0,
    output REQ_1, WE_1, FUNC3_1, ADDR_1, WDATA_1,
    input  GNT_1, RVALID_1, RDATA_1,
    input  MRd, MWrt, FUNC3, ADDR, W_DATA,
    output R_DATA
  );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Two-requester arbiter in front of a single-port DataMemory.
// IDLE grants one requester and latches its payload, ACCESS drives the
// memory for exactly one cycle, RESP (reads only) pulses RVALID.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  dmem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state;
  logic              owner;
  logic              lat_we;
  logic [2:0]        lat_func3;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_0;
  logic [DATA_W-1:0] rdata_1;

  logic              any_req;
  logic              winner;
  logic              grant_en;

  assign any_req = bus.REQ_0 | bus.REQ_1;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  // Round-robin pick: pointer breaks ties, a lone requester always wins
  always_comb begin
    winner = 1'b0;
    if (bus.REQ_0 && bus.REQ_1)
      winner = rr_ptr;
    else
      winner = ~bus.REQ_0;
  end

  // Pointer moves to the requester that lost the most recent grant
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      rr_ptr <= 1'b0;
    else if (state == S_IDLE && any_req)
      rr_ptr <= ~winner;
  end
`else
  // Fixed priority: requester 0 wins whenever it asks
  always_comb begin
    winner = ~bus.REQ_0;
  end
`endif

  // Grant is a same-cycle acknowledge, suppressed while reset is held
  assign grant_en = (state == S_IDLE) && any_req && !RESET;
  assign bus.GNT_0 = grant_en && !winner;
  assign bus.GNT_1 = grant_en &&  winner;

  // Control FSM, payload capture and read-data registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_func3 <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_0   <= '0;
      rdata_1   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner     <= winner;
            lat_we    <= winner ? bus.WE_1    : bus.WE_0;
            lat_func3 <= winner ? bus.FUNC3_1 : bus.FUNC3_0;
            lat_addr  <= winner ? bus.ADDR_1  : bus.ADDR_0;
            lat_wdata <= winner ? bus.WDATA_1 : bus.WDATA_0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_we) begin
            state <= S_IDLE;
          end else begin
            state <= S_RESP;
            if (owner)
              rdata_1 <= bus.R_DATA;
            else
              rdata_0 <= bus.R_DATA;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes exist only in ACCESS, so they can never overlap
  assign bus.MWrt   = (state == S_ACCESS) &&  lat_we;
  assign bus.MRd    = (state == S_ACCESS) && !lat_we;
  assign bus.FUNC3  = lat_func3;
  assign bus.ADDR   = lat_addr;
  assign bus.W_DATA = lat_wdata;

  assign bus.RVALID_0 = (state == S_RESP) && !owner;
  assign bus.RVALID_1 = (state == S_RESP) &&  owner;
  assign bus.RDATA_0  = rdata_0;
  assign bus.RDATA_1  = rdata_1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Bench for dmem_port_arbiter with a byte-addressed DataMemory model on the
// memory side and a transaction-level reference memory for expected reads.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;
  logic pref;                 // requester expected to win a tie
  logic [7:0] dm_mem  [0:255]; // DataMemory contents (bus-driven)
  logic [7:0] ref_mem [0:255]; // expected contents (transaction-driven)
  logic [7:0] ra;
  logic [2:0] f3_list [0:4];

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] load_value(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // DataMemory: combinational read, write on rising edge
  always_comb begin
    ra = bus.ADDR[7:0];
    bus.R_DATA = load_value(dm_mem[ra], dm_mem[ra + 8'd1], dm_mem[ra + 8'd2],
                            dm_mem[ra + 8'd3], bus.FUNC3);
  end

  always @(posedge CLK) begin
    if (bus.MWrt) begin
      dm_mem[bus.ADDR[7:0]] <= bus.W_DATA[7:0];
      if (bus.FUNC3 != 3'b000) dm_mem[bus.ADDR[7:0] + 8'd1] <= bus.W_DATA[15:8];
      if (bus.FUNC3 != 3'b000 && bus.FUNC3 != 3'b001) begin
        dm_mem[bus.ADDR[7:0] + 8'd2] <= bus.W_DATA[23:16];
        dm_mem[bus.ADDR[7:0] + 8'd3] <= bus.W_DATA[31:24];
      end
    end
  end

  // Strobes must never overlap
  always @(negedge CLK) begin
    total++;
    if (bus.MRd === 1'b1 && bus.MWrt === 1'b1) begin
      bad++;
      $display("FAIL strobe_overlap MRd=%b MWrt=%b required not both 1", bus.MRd, bus.MWrt);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic ref_store(input logic [7:0] a, input logic [2:0] f3, input logic [31:0] d);
    ref_mem[a] = d[7:0];
    if (f3 == 3'b001) ref_mem[a + 8'd1] = d[15:8];
    if (f3 != 3'b000 && f3 != 3'b001) begin
      ref_mem[a + 8'd1] = d[15:8];
      ref_mem[a + 8'd2] = d[23:16];
      ref_mem[a + 8'd3] = d[31:24];
    end
  endtask

  // One transaction from one requester, starting with the arbiter idle
  task automatic txn(input logic id, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic gs, go, vs, vo;
    logic [31:0] exp_rd, got_rd;
    logic [7:0] a;
    a = addr[7:0];
    exp_rd = load_value(ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3], f3);
    if (!id) begin
      bus.REQ_0 = 1'b1; bus.WE_0 = we; bus.FUNC3_0 = f3; bus.ADDR_0 = addr; bus.WDATA_0 = wdata;
    end else begin
      bus.REQ_1 = 1'b1; bus.WE_1 = we; bus.FUNC3_1 = f3; bus.ADDR_1 = addr; bus.WDATA_1 = wdata;
    end
    #1;
    gs = id ? bus.GNT_1 : bus.GNT_0;
    go = id ? bus.GNT_0 : bus.GNT_1;
    total++;
    if (gs !== 1'b1 || go !== 1'b0) begin
      bad++;
      $display("FAIL grant id=%0d got self=%b other=%b required self=1 other=0", id, gs, go);
    end
    pref = ~id;
    @(posedge CLK); @(negedge CLK);
    // payload may change once granted
    if (!id) begin
      bus.REQ_0 = 1'b0; bus.ADDR_0 = $urandom; bus.WDATA_0 = $urandom; bus.FUNC3_0 = 3'($urandom);
    end else begin
      bus.REQ_1 = 1'b0; bus.ADDR_1 = $urandom; bus.WDATA_1 = $urandom; bus.FUNC3_1 = 3'($urandom);
    end
    #1;
    total++;
    if (bus.MWrt !== we || bus.MRd !== ~we || bus.ADDR !== addr || bus.FUNC3 !== f3 ||
        bus.W_DATA !== wdata || bus.GNT_0 !== 1'b0 || bus.GNT_1 !== 1'b0) begin
      bad++;
      $display("FAIL access id=%0d got MWrt=%b MRd=%b ADDR=%h FUNC3=%b W_DATA=%h GNT=%b%b required MWrt=%b MRd=%b ADDR=%h FUNC3=%b W_DATA=%h GNT=00",
               id, bus.MWrt, bus.MRd, bus.ADDR, bus.FUNC3, bus.W_DATA, bus.GNT_1, bus.GNT_0,
               we, ~we, addr, f3, wdata);
    end
    @(posedge CLK); @(negedge CLK); #1;
    if (we) begin
      ref_store(a, f3, wdata);
      total++;
      if (bus.MWrt !== 1'b0 || bus.MRd !== 1'b0 || bus.RVALID_0 !== 1'b0 || bus.RVALID_1 !== 1'b0) begin
        bad++;
        $display("FAIL write_idle got MWrt=%b MRd=%b RVALID=%b%b required all 0",
                 bus.MWrt, bus.MRd, bus.RVALID_1, bus.RVALID_0);
      end
    end else begin
      vs = id ? bus.RVALID_1 : bus.RVALID_0;
      vo = id ? bus.RVALID_0 : bus.RVALID_1;
      got_rd = id ? bus.RDATA_1 : bus.RDATA_0;
      total++;
      if (vs !== 1'b1 || vo !== 1'b0 || got_rd !== exp_rd || bus.MRd !== 1'b0 || bus.MWrt !== 1'b0) begin
        bad++;
        $display("FAIL read_resp id=%0d addr=%h f3=%b got RVALID=%b/%b RDATA=%h MRd=%b MWrt=%b required RVALID=1/0 RDATA=%h MRd=0 MWrt=0",
                 id, addr, f3, vs, vo, got_rd, bus.MRd, bus.MWrt, exp_rd);
      end
      @(posedge CLK); @(negedge CLK); #1;
      total++;
      if (bus.RVALID_0 !== 1'b0 || bus.RVALID_1 !== 1'b0) begin
        bad++;
        $display("FAIL rvalid_pulse got RVALID=%b%b required 00", bus.RVALID_1, bus.RVALID_0);
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.REQ_0 = 1'b1; bus.WE_0 = 1'b1; bus.FUNC3_0 = 3'b001; bus.ADDR_0 = 32'd0; bus.WDATA_0 = 32'h000000F0;
    pref = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK); #1;
      total++;
      if (bus.GNT_0 !== 1'b0 || bus.GNT_1 !== 1'b0 || bus.MRd !== 1'b0 || bus.MWrt !== 1'b0 ||
          bus.RVALID_0 !== 1'b0 || bus.RVALID_1 !== 1'b0 || bus.RDATA_0 !== 32'd0 ||
          bus.RDATA_1 !== 32'd0 || bus.FUNC3 !== 3'd0 || bus.ADDR !== 32'd0 || bus.W_DATA !== 32'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got GNT=%b%b MRd=%b MWrt=%b RVALID=%b%b RDATA0=%h RDATA1=%h FUNC3=%b ADDR=%h W_DATA=%h required all 0",
                 c, bus.GNT_1, bus.GNT_0, bus.MRd, bus.MWrt, bus.RVALID_1, bus.RVALID_0,
                 bus.RDATA_0, bus.RDATA_1, bus.FUNC3, bus.ADDR, bus.W_DATA);
      end
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_write();
    txn(1'b0, 1'b1, 3'b001, 32'd0, 32'h000000F0);
  endtask

  task automatic test_read_back();
    txn(1'b0, 1'b0, 3'b001, 32'd0, $urandom);
  endtask

  task automatic test_contention();
    logic w, g0, g1;
    bus.REQ_0 = 1'b1; bus.WE_0 = 1'b1; bus.FUNC3_0 = 3'b000; bus.ADDR_0 = 32'd200; bus.WDATA_0 = 32'h000000A5;
    bus.REQ_1 = 1'b1; bus.WE_1 = 1'b1; bus.FUNC3_1 = 3'b000; bus.ADDR_1 = 32'd201; bus.WDATA_1 = 32'h0000005A;
    for (int c = 0; c < 12; c++) begin
      #1;
      g0 = bus.GNT_0;
      g1 = bus.GNT_1;
      total++;
      if (c % 2 == 0) begin
`ifdef DMEM_ARB_RR_EN
        w = pref;
`else
        w = 1'b0;
`endif
        if (g0 !== ~w || g1 !== w) begin
          bad++;
          $display("FAIL contention_grant cycle=%0d got GNT1=%b GNT0=%b required GNT1=%b GNT0=%b", c, g1, g0, w, ~w);
        end
        pref = ~w;
        if (w) ref_store(8'd201, 3'b000, 32'h5A);
        else   ref_store(8'd200, 3'b000, 32'hA5);
      end else if (g0 !== 1'b0 || g1 !== 1'b0) begin
        bad++;
        $display("FAIL contention_busy cycle=%0d got GNT1=%b GNT0=%b required 0 0", c, g1, g0);
      end
      @(posedge CLK); @(negedge CLK);
    end
    bus.REQ_0 = 1'b0;
    bus.REQ_1 = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    for (int i = 1; i < 128; i++) begin
      d = 32'(i * 13);
      if (i % 2 == 1) d = -d;
      txn(1'b1, 1'b1, 3'b000, 32'(i), d);
    end
    for (int i = 0; i < 60; i++)
      txn(1'b0, 1'b0, f3_list[$urandom_range(0, 4)], 32'(i), $urandom);
  endtask

  task automatic test_random();
    for (int n = 0; n < 50; n++)
      txn(1'($urandom), 1'($urandom), f3_list[$urandom_range(0, 4)],
          32'($urandom_range(0, 127)), $urandom);
  endtask

  task automatic test_abort();
    bus.REQ_0 = 1'b1; bus.WE_0 = 1'b0; bus.FUNC3_0 = 3'b010; bus.ADDR_0 = 32'd4; bus.WDATA_0 = 32'd0;
    #1;
    total++;
    if (bus.GNT_0 !== 1'b1) begin
      bad++;
      $display("FAIL abort_grant got GNT0=%b required 1", bus.GNT_0);
    end
    @(posedge CLK); @(negedge CLK);
    bus.REQ_0 = 1'b0;
    #1;
    total++;
    if (bus.MRd !== 1'b1) begin
      bad++;
      $display("FAIL abort_access got MRd=%b required 1", bus.MRd);
    end
    RESET = 1'b1;
    #1;
    total++;
    if (bus.MRd !== 1'b0 || bus.MWrt !== 1'b0 || bus.ADDR !== 32'd0 || bus.FUNC3 !== 3'd0) begin
      bad++;
      $display("FAIL abort_reset got MRd=%b MWrt=%b ADDR=%h FUNC3=%b required 0 0 0 0",
               bus.MRd, bus.MWrt, bus.ADDR, bus.FUNC3);
    end
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    RESET = 1'b0;
    pref = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus.RVALID_0 !== 1'b0 || bus.RVALID_1 !== 1'b0 || bus.MRd !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_rvalid cycle=%0d got RVALID=%b%b MRd=%b required 0", c,
                 bus.RVALID_1, bus.RVALID_0, bus.MRd);
      end
      @(posedge CLK); @(negedge CLK);
    end
    txn(1'b0, 1'b0, 3'b010, 32'd4, $urandom);
  endtask

  initial begin
    total = 0;
    bad = 0;
    RESET = 1'b1;
    f3_list[0] = 3'b000; f3_list[1] = 3'b001; f3_list[2] = 3'b010;
    f3_list[3] = 3'b100; f3_list[4] = 3'b101;
    for (int i = 0; i < 256; i++) begin
      dm_mem[i]  = 8'd0;
      ref_mem[i] = 8'd0;
    end
    bus.REQ_0 = 1'b0; bus.WE_0 = 1'b0; bus.FUNC3_0 = 3'd0; bus.ADDR_0 = 32'd0; bus.WDATA_0 = 32'd0;
    bus.REQ_1 = 1'b0; bus.WE_1 = 1'b0; bus.FUNC3_1 = 3'd0; bus.ADDR_1 = 32'd0; bus.WDATA_1 = 32'd0;

    test_reset();
    test_write();
    test_read_back();
    test_contention();
    test_sweep();
    test_random();
    test_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
